card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
- Upstream card source for blackjackGame.
- Holds a 52-card deck as a "used" bitmask and deals one unused card per request, with pseudo-random selection from an LFSR.
- Reports cards remaining, and reshuffles automatically when the deck is exhausted.
- The game FSM issues deal_req when it needs a card for the dealer or player, then waits for card_valid.

Parameters:
- RANDOMIZE, 1: 1 = LFSR-chosen start index; 0 = start index is always 0, giving an ascending deterministic deal order for verification.
- SEED, 16'hACE1: LFSR reset value. If SEED==0, the LFSR loads 16'h0001 instead.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- deal_req  in  1  one-cycle request for one card; sampled only in IDLE.
- shuffle  in  1  one-cycle request to return all cards to the deck.
- card_valid  out  1  one-cycle pulse: card_* fields hold a newly dealt card.
- card_rank  out  4  1..13 (1=A, 11=J, 12=Q, 13=K); held until the next deal.
- card_suit  out  2  0..3; held until the next deal.
- card_points  out  4  A=1, 2..10=face value, J/Q/K=10; held until the next deal.
- busy  out  1  high in any state other than IDLE.
- cards_left  out  6  unused cards remaining, 0..52.
- reshuffled  out  1  one-cycle pulse when the deck auto-refills on an empty-deck deal.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, used=0, cards_left=52, lfsr=SEED.
  - All card_* outputs and all pulses = 0.
- Reset mid-operation aborts the search; no card_valid is issued.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clock, free-running regardless of state.
- Index mapping: idx 0..51 maps to rank = idx%13+1 and suit = idx/13.
- FSM states: IDLE, PICK, PROBE, DEAL.
- IDLE:
  - If shuffle: used<=0, cards_left<=52.
  - Else if deal_req and cards_left==0: used<=0, cards_left<=52, reshuffled pulse, go to PICK.
  - Else if deal_req: go to PICK.
  - shuffle and deal_req in the same cycle: shuffle is applied and the request is dropped. The requester must re-issue it.
- PICK:
  - RANDOMIZE=0: idx<=0, go to PROBE.
  - RANDOMIZE=1: if lfsr[5:0]<52 then idx<=lfsr[5:0] and go to PROBE; otherwise stay in PICK (retry next cycle).
- PROBE:
  - If used[idx]==0: load card_rank/suit/points from idx, set used[idx], cards_left--, go to DEAL.
  - Otherwise: idx <= (idx==51) ? 0 : idx+1, stay in PROBE.
  - Termination is guaranteed because cards_left>=1 on entry.
- DEAL: card_valid=1 for exactly this cycle, then go to IDLE.
- Latency, from the edge that samples deal_req to card_valid high:
  - 3 cycles, plus 1 per occupied slot probed, plus 1 per PICK rejection.
  - With RANDOMIZE=0, the nth deal since refill has latency n+2.
- deal_req while busy: ignored, not queued.
- shuffle while busy: aborts to IDLE, clears used, sets cards_left=52, no card_valid.
- cards_left never underflows; the empty condition is detected only in IDLE.
- No card index is dealt twice between refills. Exactly 52 distinct cards are dealt per refill.

Decomposition:
- Package blackjack_card_pkg:
  - rank_t (4b), suit_t (2b), points_t (4b), DECK_SIZE=52, RANKS=13.
  - Functions idx_to_rank, idx_to_suit, rank_to_points.
  - Shared with blackjackGame hand summation.
- Sub-module lfsr16: clk, reset, SEED parameter, 16-bit state output, free-running, nonzero-seed guard.

Test Plan:
- Reset, then RANDOMIZE=0, one deal_req → card_valid 3 cycles later; rank=1, suit=0, points=1, cards_left=51, busy high for 3 cycles.
- RANDOMIZE=0, 13 sequential deals → 13th card is rank=13, suit=0, points=10, latency 15; 14th card is rank=1, suit=1.
- RANDOMIZE=0, 52 deals then a 53rd → reshuffled pulses once, 53rd card is rank=1, suit=0, cards_left=51.
- RANDOMIZE=1, 52 deals → all 52 (rank,suit) pairs unique, cards_left=0, no reshuffled pulse.
- deal_req pulsed while busy → ignored, single card_valid. shuffle mid-PROBE → no card_valid, cards_left=52.
- reset asserted (low) during PROBE → immediate IDLE, busy=0, cards_left=52, outputs 0, no card_valid after release.

Source files
------------

// File: rtl/blackjack_card_pkg.sv
// blackjack_card_pkg: card types and index-to-card helpers shared by the dealer and hand summation
package blackjack_card_pkg;

    typedef logic [3:0] rank_t;
    typedef logic [1:0] suit_t;
    typedef logic [3:0] points_t;
    typedef logic [5:0] idx_t;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;

    localparam idx_t LAST_IDX  = idx_t'(DECK_SIZE - 1);
    localparam idx_t FULL_DECK = idx_t'(DECK_SIZE);

    typedef enum logic [1:0] {IDLE, PICK, PROBE, DEAL} state_t;

    function automatic rank_t idx_to_rank(input idx_t idx);
        return rank_t'(idx % idx_t'(RANKS) + idx_t'(1));
    endfunction

    function automatic suit_t idx_to_suit(input idx_t idx);
        return suit_t'(idx / idx_t'(RANKS));
    endfunction

    function automatic points_t rank_to_points(input rank_t rank);
        return (rank > 4'd10) ? 4'd10 : rank;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with an all-zero seed guard
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state
);

    // An all-zero state would lock the register, so fall back to 1
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= INIT;
        else
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end

endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals unused cards from a 52-card deck on request, refilling when empty
module card_dealer
    import blackjack_card_pkg::*;
#(
    parameter bit          RANDOMIZE = 1'b1,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    deal_req,
    input  logic    shuffle,
    output logic    card_valid,
    output rank_t   card_rank,
    output suit_t   card_suit,
    output points_t card_points,
    output logic    busy,
    output idx_t    cards_left,
    output logic    reshuffled
);

    state_t                 state;
    logic [DECK_SIZE-1:0]   used;
    idx_t                   idx;
    logic [15:0]            lfsr;
    idx_t                   pick;
    logic                   unused_lfsr;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr)
    );

    assign pick        = lfsr[5:0];
    assign unused_lfsr = ^lfsr[15:6];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            used        <= '0;
            idx         <= '0;
            cards_left  <= FULL_DECK;
            card_valid  <= 1'b0;
            card_rank   <= '0;
            card_suit   <= '0;
            card_points <= '0;
            busy        <= 1'b0;
            reshuffled  <= 1'b0;
        end else begin
            card_valid <= 1'b0;
            reshuffled <= 1'b0;
            // shuffle wins in every state and drops any request in flight
            if (shuffle) begin
                state      <= IDLE;
                busy       <= 1'b0;
                used       <= '0;
                cards_left <= FULL_DECK;
            end else begin
                case (state)
                    IDLE: if (deal_req) begin
                        if (cards_left == '0) begin
                            used       <= '0;
                            cards_left <= FULL_DECK;
                            reshuffled <= 1'b1;
                        end
                        state <= PICK;
                        busy  <= 1'b1;
                    end
                    PICK: if (!RANDOMIZE) begin
                        idx   <= '0;
                        state <= PROBE;
                    end else if (pick <= LAST_IDX) begin
                        idx   <= pick;
                        state <= PROBE;
                    end
                    // at least one slot is free here, so the linear scan terminates
                    PROBE: if (!used[idx]) begin
                        card_rank   <= idx_to_rank(idx);
                        card_suit   <= idx_to_suit(idx);
                        card_points <= rank_to_points(idx_to_rank(idx));
                        used[idx]   <= 1'b1;
                        cards_left  <= cards_left - idx_t'(1);
                        card_valid  <= 1'b1;
                        state       <= DEAL;
                    end else begin
                        idx <= (idx == LAST_IDX) ? '0 : idx + idx_t'(1);
                    end
                    DEAL: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: random-stimulus bench for card_dealer against a deck-level reference model
module tb_card_dealer;
    import blackjack_card_pkg::*;

    logic    clk = 1'b0;
    logic    reset = 1'b0;
    logic    deal0 = 1'b0, shuf0 = 1'b0, deal1 = 1'b0, shuf1 = 1'b0;
    logic    cv0, busy0, rs0, cv1, busy1, rs1;
    rank_t   rank0, rank1;
    suit_t   suit0, suit1;
    points_t pts0, pts1;
    idx_t    left0, left1;

    int errors = 0, checks = 0;
    int ncv0 = 0, nrs0 = 0, ncv1 = 0, nrs1 = 0;
    bit mused[52];
    int mleft = 52;

    always #5 clk = ~clk;

    card_dealer #(.RANDOMIZE(1'b0), .SEED(16'h0000)) dut0 (
        .clk(clk), .reset(reset), .deal_req(deal0), .shuffle(shuf0),
        .card_valid(cv0), .card_rank(rank0), .card_suit(suit0), .card_points(pts0),
        .busy(busy0), .cards_left(left0), .reshuffled(rs0)
    );

    card_dealer #(.RANDOMIZE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .deal_req(deal1), .shuffle(shuf1),
        .card_valid(cv1), .card_rank(rank1), .card_suit(suit1), .card_points(pts1),
        .busy(busy1), .cards_left(left1), .reshuffled(rs1)
    );

    always @(negedge clk) begin
        if (cv0) ncv0++;
        if (rs0) nrs0++;
        if (cv1) ncv1++;
        if (rs1) nrs1++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pts_of(input int rank);
        return rank > 10 ? 10 : rank;
    endfunction

    task automatic model_clear();
        foreach (mused[i]) mused[i] = 1'b0;
        mleft = 52;
    endtask

    // Fixed-order deck: the lowest free index is dealt, after probing every used slot below it
    task automatic model_deal(output int idx, output bit resh);
        resh = (mleft == 0);
        if (resh) model_clear();
        idx = 0;
        while (mused[idx]) idx++;
        mused[idx] = 1'b1;
        mleft--;
    endtask

    task automatic deal(input int which, output int lat, output int nbusy);
        bit got = 1'b0;
        lat = 0;
        nbusy = 0;
        @(negedge clk);
        if (which == 0) deal0 = 1'b1; else deal1 = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 deal0 = 1'b0;
        deal1 = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (which == 0 ? busy0 : busy1) nbusy++;
            if (which == 0 ? cv0 : cv1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!got) chk("deal_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic deal0_checked();
        int idx, lat, nb, r0, rank;
        bit resh;
        r0 = nrs0;
        model_deal(idx, resh);
        deal(0, lat, nb);
        rank = idx % 13 + 1;
        chk("d0.lat", lat, idx + 3);
        chk("d0.busy_cycles", nb, idx + 3);
        chk("d0.rank", rank0, rank);
        chk("d0.suit", suit0, idx / 13);
        chk("d0.points", pts0, pts_of(rank));
        chk("d0.left", left0, mleft);
        chk("d0.reshuffled", nrs0 - r0, resh);
        chk("d0.valid_1cyc", cv0, 0);
    endtask

    task automatic shuffle0(input bit with_deal);
        int c0 = ncv0;
        @(negedge clk);
        shuf0 = 1'b1;
        deal0 = with_deal;
        @(posedge clk);
        #1 shuf0 = 1'b0;
        deal0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        model_clear();
        chk("sh.no_valid", ncv0 - c0, 0);
        chk("sh.left", left0, 52);
        chk("sh.busy", busy0, 0);
    endtask

    initial begin
        int idx, lat, nb, c0, r1, rank, sidx;
        bit resh;
        bit seen[64];

        repeat (2) @(posedge clk);
        #1;
        chk("rst.left0", left0, 52);
        chk("rst.busy0", busy0, 0);
        chk("rst.valid0", cv0, 0);
        chk("rst.rank0", rank0, 0);
        chk("rst.suit0", suit0, 0);
        chk("rst.pts0", pts0, 0);
        chk("rst.rs0", rs0, 0);
        chk("rst.left1", left1, 52);
        chk("rst.busy1", busy1, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Ascending deal order across a full deck plus the refilling 53rd deal
        for (int n = 0; n < 53; n++) deal0_checked();
        chk("fixed.rs_total", nrs0, 1);

        // A second request while busy is dropped
        c0 = ncv0;
        model_deal(idx, resh);
        @(negedge clk) deal0 = 1'b1;
        @(posedge clk);
        #1 deal0 = 1'b0;
        @(negedge clk) deal0 = 1'b1;
        @(posedge clk);
        #1 deal0 = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        chk("busy_req.cv", ncv0 - c0, 1);
        chk("busy_req.left", left0, mleft);
        chk("busy_req.rank", rank0, idx % 13 + 1);
        chk("busy_req.suit", suit0, idx / 13);

        // Shuffle during PROBE aborts the deal
        c0 = ncv0;
        @(negedge clk) deal0 = 1'b1;
        @(posedge clk);
        #1 deal0 = 1'b0;
        @(posedge clk);
        @(negedge clk) shuf0 = 1'b1;
        @(posedge clk);
        #1 shuf0 = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        model_clear();
        chk("abort.cv", ncv0 - c0, 0);
        chk("abort.left", left0, 52);
        chk("abort.busy", busy0, 0);
        deal0_checked();

        // Random mix of deals, idle shuffles and shuffle colliding with a request
        for (int n = 0; n < 150; n++) begin
            int op = $urandom_range(0, 11);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if (op == 0) shuffle0(1'b0);
            else if (op == 1) shuffle0(1'b1);
            else deal0_checked();
        end

        // Randomized order: one full deck of distinct cards
        foreach (seen[i]) seen[i] = 1'b0;
        r1 = nrs1;
        for (int n = 0; n < 52; n++) begin
            deal(1, lat, nb);
            rank = int'(rank1);
            chk("rnd.rank_range", (rank >= 1 && rank <= 13), 1);
            chk("rnd.points", pts1, pts_of(rank));
            sidx = (int'(suit1) * 13 + rank - 1) & 63;
            chk("rnd.unique", seen[sidx], 0);
            seen[sidx] = 1'b1;
            chk("rnd.left", left1, 51 - n);
            chk("rnd.busy_cycles", nb, lat);
        end
        chk("rnd.no_reshuffle", nrs1 - r1, 0);
        chk("rnd.empty", left1, 0);
        deal(1, lat, nb);
        chk("rnd.refill_rs", nrs1 - r1, 1);
        chk("rnd.refill_left", left1, 51);

        // Reset during a deal in progress
        c0 = ncv0;
        @(negedge clk) deal0 = 1'b1;
        @(posedge clk);
        #1 deal0 = 1'b0;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("arst.busy", busy0, 0);
        chk("arst.left", left0, 52);
        chk("arst.valid", cv0, 0);
        chk("arst.rank", rank0, 0);
        chk("arst.suit", suit0, 0);
        chk("arst.pts", pts0, 0);
        chk("arst.left1", left1, 52);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        model_clear();
        chk("arst.no_valid", ncv0 - c0, 0);
        chk("arst.idle", busy0, 0);
        deal0_checked();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
